// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo; slave is the FIFO side, master the user side.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  logic                     we_i;
  logic [DATA_WIDTH-1:0]    din_i;
  logic                     wrdy_o;
  logic                     re_i;
  logic [DATA_WIDTH-1:0]    dout_o;
  logic                     rrdy_o;
  logic [$clog2(DEPTH):0]   count_o;
  logic                     afull_o;
  logic                     aempty_o;
  logic                     ovf_o;
  logic                     udf_o;

  modport slave (
    input  we_i, din_i, re_i,
    output wrdy_o, dout_o, rrdy_o, count_o, afull_o, aempty_o, ovf_o, udf_o
  );

  modport master (
    output we_i, din_i, re_i,
    input  wrdy_o, dout_o, rrdy_o, count_o, afull_o, aempty_o, ovf_o, udf_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, threshold flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_THR  = DEPTH - 1,
  parameter int unsigned AEMPTY_THR = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sync_fifo_if.slave     bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AfullThr  = PW'(AFULL_THR);
  localparam logic [PW-1:0] AemptyThr = PW'(AEMPTY_THR);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [PW-1:0]         count;

  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign count  = wr_ptr_q - rd_ptr_q;
  // Acceptance depends only on registered full/empty, so no write/read pass-through.
  assign wr_acc = bus.we_i && !full && !rst_i;
  assign rd_acc = bus.re_i && !empty && !rst_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (bus.we_i && full)  ovf_d = 1'b1;
    if (bus.re_i && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= bus.din_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.dout_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.dout_o = dout_q;
`endif

  assign bus.wrdy_o   = !full;
  assign bus.rrdy_o   = !empty;
  assign bus.count_o  = count;
  assign bus.afull_o  = (count >= AfullThr);
  assign bus.aempty_o = (count <= AemptyThr);
  assign bus.ovf_o    = ovf_q;
  assign bus.udf_o    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFT   = DEPTH - 1;
  localparam int unsigned AET   = 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_THR  (AFT),
    .AEMPTY_THR (AET)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_ovf  = 1'b0;
  logic          exp_udf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare every output.
  task automatic step(input logic rst, input logic we, input logic re, input logic [DW-1:0] din);
    int unsigned sz;
    rst_i      = rst;
    bus.we_i   = we;
    bus.re_i   = re;
    bus.din_i  = din;
    @(posedge clk_i);
    #1;
    sz = model_q.size();
    if (rst) begin
      model_q.delete();
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
      exp_dout = '0;
    end else begin
      if (we && sz == DEPTH) exp_ovf = 1'b1;
      if (re && sz == 0)     exp_udf = 1'b1;
      if (re && sz > 0)      exp_dout = model_q.pop_front();
      if (we && sz < DEPTH)  model_q.push_back(din);
    end
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = (model_q.size() > 0) ? model_q[0] : '0;
`endif
    sz = model_q.size();
    check("count",  32'(bus.count_o),  sz);
    check("wrdy",   32'(bus.wrdy_o),   32'(sz < DEPTH));
    check("rrdy",   32'(bus.rrdy_o),   32'(sz > 0));
    check("afull",  32'(bus.afull_o),  32'(sz >= AFT));
    check("aempty", 32'(bus.aempty_o), 32'(sz <= AET));
    check("ovf",    32'(bus.ovf_o),    32'(exp_ovf));
    check("udf",    32'(bus.udf_o),    32'(exp_udf));
    check("dout",   32'(bus.dout_o),   32'(exp_dout));
  endtask

  initial begin
    bus.we_i  = 1'b0;
    bus.re_i  = 1'b0;
    bus.din_i = '0;

    // Reset, then three writes and three reads.
    step(1, 0, 0, 0);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Fill to full, overflow attempt, drain.
    step(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DW'(i));
    step(0, 1, 0, 8'hFF);
    step(0, 1, 1, 8'hEE);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0);

    // Underflow on empty stays sticky until reset.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 8'h5A);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Steady occupancy of 4 across pointer wrap.
    for (int i = 0; i < 4; i++) step(0, 1, 0, DW'(8'hC0 + i));
    for (int i = 0; i < 20; i++) step(0, 1, 1, DW'($urandom));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // Reset mid-operation with count 5; requests during reset are ignored.
    for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(8'h70 + i));
    step(0, 1, 0, 8'h99);
    step(0, 0, 1, 0);
    step(1, 1, 1, 8'h42);
    step(0, 0, 0, 0);

    // Random traffic with biased phases to reach both full and empty.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      logic r, w, rd;
      wp = ((i / 150) % 3 == 0) ? 80 : (((i / 150) % 3 == 1) ? 20 : 50);
      r  = ($urandom_range(0, 199) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      step(r, w, rd, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
